dds_hop_scheduler: RTL
======================

# dds_hop_scheduler

Sequences frequency loads into the AD9850 serial-loader FSM. It holds a small table of 32-bit tuning words and steps through them with a programmable dwell time. It also arbitrates a one-shot manual load request against the hop sequence. It sits between the control/switch logic and the serial loader, and talks to the loader over a valid/ready request plus a done pulse.

## Interface
- NUM_SLOTS, 4, number of tuning-word table entries (power of 2, ≥2)
- TW_WIDTH, 32, tuning word width
- DWELL_WIDTH, 24, dwell counter width (clk cycles)
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk
- cfg_we  in  1  write cfg_tw into table slot cfg_addr
- cfg_addr  in  $clog2(NUM_SLOTS)  table write address
- cfg_tw  in  TW_WIDTH  tuning word to store
- enable  in  1  hop sequence run (level)
- num_active  in  $clog2(NUM_SLOTS)+1  slots in sequence, 0 treated as 1, >NUM_SLOTS clamped to NUM_SLOTS
- dwell_cycles  in  DWELL_WIDTH  cycles between load completion and next hop, 0 treated as 1
- manual_req  in  1  request one load of manual_tw (level, held until manual_ack)
- manual_tw  in  TW_WIDTH  manual tuning word
- manual_ack  out  1  one-cycle pulse when manual load completes
- ld_valid  out  1  load request to serial loader
- ld_tw  out  TW_WIDTH  tuning word for loader, stable while ld_valid
- ld_ready  in  1  loader accepts request when ld_valid && ld_ready
- ld_done  in  1  one-cycle pulse from loader after FQ_UD
- cur_slot  out  $clog2(NUM_SLOTS)  slot of last issued hop load
- busy  out  1  high in ISSUE or WAIT_DONE

## Operation
- States: IDLE, ISSUE, WAIT_DONE, DWELL (in shared enum).
- IDLE: manual_req → ISSUE(manual). Otherwise a rising enable (enable=1, prior-cycle enable=0) → ISSUE(hop) with slot pointer reset to 0.
- ISSUE: ld_valid=1, ld_tw latched on entry. Leaves for WAIT_DONE on the cycle where ld_valid && ld_ready.
- WAIT_DONE: waits for ld_done. On ld_done:
  - manual load: pulse manual_ack.
  - hop load: cur_slot ← pointer.
  - Then go to DWELL if enable=1, else IDLE.
- DWELL: counter runs 0..dwell_cycles-1.
  - manual_req has priority: → ISSUE(manual); the counter restarts after that load.
  - At terminal count: pointer ← (pointer+1) wraps to 0 at num_active-1; → ISSUE(hop).
  - enable=0 → IDLE immediately.
- Table: written only via cfg_we. The read for ISSUE uses the pre-write value when cfg_we hits the same slot in the same cycle. Issued ld_tw is never altered mid-handshake.
- Arbitration: manual beats hop when both are eligible in the same cycle. A pending hop issues after the manual load completes, following a fresh dwell.
- enable falling during ISSUE/WAIT_DONE: the load completes normally, then → IDLE.
- ld_done outside WAIT_DONE is ignored. ld_ready outside ISSUE is ignored.
- reset_n=0 mid-operation: all state cleared on that edge. A loader request is dropped without completion.

## Timing
- Reset values: ld_valid=0, ld_tw=0, manual_ack=0, busy=0, cur_slot=0, table entries=0, state=IDLE, pointer=0, dwell counter=0.
- Enable rising sampled at edge t → ld_valid=1 from t+1.
- With ld_ready=1, the accept happens in the first ISSUE cycle; ld_valid=0 the next cycle.
- ld_done at edge t:
  - manual_ack=1 during cycle t+1 only.
  - DWELL entered at t+1.
  - Next hop ld_valid=1 at t+1+dwell_cycles.
- cfg_we write visible to an ISSUE entered one or more cycles later.
- All outputs registered. No combinational path from inputs to outputs.

## Structure
- Package dds_pkg:
  - state enum sched_state_t
  - TW_WIDTH default
  - AD9850 control byte constant (8'h00) shared with the loader
  - REF_CLK constant for tuning-word computation
- Sub-module dds_tw_table: NUM_SLOTS×TW_WIDTH register file, one write port, one synchronous read-before-write port.
- Scheduler FSM, dwell counter and arbitration live in dds_hop_scheduler.

## Test plan
- Reset, write slots 0..3 = 0x28F5C28F, 0x147AE147, 0x0A3D70A3, 0x051EB851, num_active=3, dwell_cycles=10, ld_ready=1, ld_done 5 cycles after accept → ld_tw sequence 0x28F5C28F, 0x147AE147, 0x0A3D70A3, 0x28F5C28F. Each issue occurs 11 cycles after the previous ld_done.
- manual_req with manual_tw=0x1234_5678 asserted in DWELL → next issue is 0x12345678, manual_ack pulses one cycle after ld_done, hop resumes with the next slot after a full dwell.
- ld_ready held 0 for 7 cycles in ISSUE → ld_valid and ld_tw stable all 7 cycles; single accept; no duplicate request.
- cfg_we to the current pointer's next slot in the same cycle as its ISSUE → old value issued; the new value is issued on the following wrap.
- enable dropped during WAIT_DONE → the load completes, state is IDLE, and no further ld_valid appears. enable re-raised → slot 0 issued.
- reset_n=0 for 1 cycle during WAIT_DONE → the next cycle shows all outputs at reset values and busy=0.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the AD9850 hop scheduler and serial loader.
// Both sides of the loader handshake import this package.
package dds_pkg;

  localparam int TW_WIDTH = 32;

  localparam logic [7:0] AD9850_CTRL = 8'h00;

  // AD9850 reference clock; tw = f_out * 2^32 / REF_CLK_HZ
  localparam longint REF_CLK_HZ = 125_000_000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    DWELL
  } sched_state_t;

endpackage

// File: rtl/dds_tw_table.sv
// Tuning-word register file for the hop scheduler.
// One write port and one registered read port that returns pre-write data.
module dds_tw_table #(
  parameter int NUM_SLOTS = 4,
  parameter int TW_WIDTH = dds_pkg::TW_WIDTH,
  localparam int AW = $clog2(NUM_SLOTS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [TW_WIDTH-1:0] i_wdata,
  input  logic                i_rd_en,
  input  logic [AW-1:0]       i_raddr,
  output logic [TW_WIDTH-1:0] o_rdata
);

  logic [TW_WIDTH-1:0] r_mem [NUM_SLOTS];
  logic [TW_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      if (i_rd_en) begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dds_hop_scheduler.sv
// Steps the AD9850 loader through a tuning-word table with a dwell time,
// and slots one-shot manual loads in ahead of pending hops.
module dds_hop_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int TW_WIDTH = dds_pkg::TW_WIDTH,
  parameter int DWELL_WIDTH = 24,
  localparam int AW = $clog2(NUM_SLOTS),
  localparam int NW = AW + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [TW_WIDTH-1:0]    cfg_tw,
  input  logic                   enable,
  input  logic [NW-1:0]          num_active,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  input  logic                   manual_req,
  input  logic [TW_WIDTH-1:0]    manual_tw,
  output logic                   manual_ack,
  output logic                   ld_valid,
  output logic [TW_WIDTH-1:0]    ld_tw,
  input  logic                   ld_ready,
  input  logic                   ld_done,
  output logic [AW-1:0]          cur_slot,
  output logic                   busy
);

  import dds_pkg::*;

  sched_state_t r_state;
  sched_state_t w_nxt_state;

  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_nxt_ptr;
  logic [AW-1:0] w_last;
  logic [AW-1:0] w_ptr_inc;
  logic [AW-1:0] w_hop_ptr;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] r_cur_slot;

  logic [DWELL_WIDTH-1:0] r_cnt;
  logic [DWELL_WIDTH-1:0] w_nxt_cnt;
  logic [DWELL_WIDTH-1:0] w_dwell_last;

  logic r_man;
  logic w_nxt_man;
  logic r_pend;
  logic w_nxt_pend;
  logic r_en_d;
  logic w_rise;
  logic r_ld_valid;
  logic r_busy;
  logic r_ack;
  logic w_ack;
  logic w_upd_slot;
  logic w_man_ld;
  logic w_rd_en;

  logic [TW_WIDTH-1:0] r_man_tw;
  logic [TW_WIDTH-1:0] w_tbl_rd;

  dds_tw_table #(
    .NUM_SLOTS(NUM_SLOTS),
    .TW_WIDTH (TW_WIDTH)
  ) u_table (
    .clk    (clk),
    .reset_n(reset_n),
    .i_we   (cfg_we),
    .i_waddr(cfg_addr),
    .i_wdata(cfg_tw),
    .i_rd_en(w_rd_en),
    .i_raddr(w_rd_addr),
    .o_rdata(w_tbl_rd)
  );

  always_comb begin
    if (num_active == '0) begin
      w_last = '0;
    end else if (num_active > NW'(NUM_SLOTS)) begin
      w_last = AW'(NUM_SLOTS - 1);
    end else begin
      w_last = AW'(num_active - 1'b1);
    end
  end

  assign w_dwell_last = (dwell_cycles == '0) ? '0
                      : dwell_cycles - 1'b1;
  assign w_ptr_inc = (r_ptr >= w_last) ? '0
                   : r_ptr + 1'b1;
  // a hop deferred behind a manual load restarts at slot 0
  assign w_hop_ptr = r_pend ? '0 : w_ptr_inc;
  assign w_rise = enable & ~r_en_d;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_man   = r_man;
    w_nxt_pend  = r_pend;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_ptr;
    w_man_ld    = 1'b0;
    w_ack       = 1'b0;
    w_upd_slot  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (manual_req) begin
          w_nxt_state = ISSUE;
          w_nxt_man   = 1'b1;
          w_man_ld    = 1'b1;
          w_nxt_pend  = w_rise;
        end else if (w_rise) begin
          w_nxt_state = ISSUE;
          w_nxt_man   = 1'b0;
          w_nxt_ptr   = '0;
          w_nxt_pend  = 1'b0;
          w_rd_en     = 1'b1;
          w_rd_addr   = '0;
        end
      end
      ISSUE: begin
        if (w_rise) begin
          w_nxt_pend = 1'b1;
        end
        if (ld_ready) begin
          w_nxt_state = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (w_rise) begin
          w_nxt_pend = 1'b1;
        end
        if (ld_done) begin
          w_ack      = r_man;
          w_upd_slot = ~r_man;
          w_nxt_cnt  = '0;
          if (enable) begin
            w_nxt_state = DWELL;
          end else begin
            w_nxt_state = IDLE;
            w_nxt_pend  = 1'b0;
          end
        end
      end
      DWELL: begin
        w_nxt_cnt = r_cnt + 1'b1;
        if (manual_req) begin
          w_nxt_state = ISSUE;
          w_nxt_man   = 1'b1;
          w_man_ld    = 1'b1;
          w_nxt_cnt   = '0;
        end else if (!enable) begin
          w_nxt_state = IDLE;
          w_nxt_pend  = 1'b0;
          w_nxt_cnt   = '0;
        end else if (r_cnt >= w_dwell_last) begin
          w_nxt_state = ISSUE;
          w_nxt_man   = 1'b0;
          w_nxt_ptr   = w_hop_ptr;
          w_nxt_pend  = 1'b0;
          w_nxt_cnt   = '0;
          w_rd_en     = 1'b1;
          w_rd_addr   = w_hop_ptr;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_man      <= 1'b0;
      r_pend     <= 1'b0;
      r_en_d     <= 1'b0;
      r_ld_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_cur_slot <= '0;
      r_man_tw   <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_ptr      <= w_nxt_ptr;
      r_cnt      <= w_nxt_cnt;
      r_man      <= w_nxt_man;
      r_pend     <= w_nxt_pend;
      r_en_d     <= enable;
      r_ld_valid <= (w_nxt_state == ISSUE);
      r_busy     <= (w_nxt_state == ISSUE)
                 || (w_nxt_state == WAIT_DONE);
      r_ack      <= w_ack;
      if (w_upd_slot) begin
        r_cur_slot <= r_ptr;
      end
      if (w_man_ld) begin
        r_man_tw <= manual_tw;
      end
    end
  end

  assign ld_valid   = r_ld_valid;
  assign ld_tw      = r_man ? r_man_tw : w_tbl_rd;
  assign manual_ack = r_ack;
  assign cur_slot   = r_cur_slot;
  assign busy       = r_busy;

endmodule
